// File: rtl/aes_tx.sv
// aes_tx: serialises a 128-bit result block onto an 8-bit bus, byte 0 first.
// Each byte is presented with shakehand low for STROBE_LOW cycles and then
// with shakehand high for STROBE_HIGH cycles. The receiver captures tx on the
// rising edge of shakehand. Handshake: a block is accepted when en=1 at a
// rising clk edge while the FSM is IDLE. en is ignored while busy=1. There is
// no back-pressure: once a block is accepted, all 16 bytes are sent, unless
// rst_n aborts the transfer. done pulses for one cycle after the last byte.
// All outputs come straight from registers. state_o exposes the FSM state
// (0=IDLE, 1=SETUP, 2=STROBE) for debug.
module aes_tx #(
   parameter int unsigned STROBE_LOW  = 2,
   parameter int unsigned STROBE_HIGH = 2
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [127:0] data,
   input  logic         en,
   output logic [7:0]   tx,
   output logic         shakehand,
   output logic         busy,
   output logic         done,
   output logic [1:0]   state_o
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      STROBE = 2'd2
   } state_t;

   // The phase counter counts down to zero, so it is reloaded with length-1.
   localparam logic [3:0] LOW_RELOAD  = 4'(STROBE_LOW - 1);
   localparam logic [3:0] HIGH_RELOAD = 4'(STROBE_HIGH - 1);

   state_t         state_q;
   logic [127:0]   buf_q;
   logic [3:0]     idx_q;
   logic [3:0]     cnt_q;
   logic [7:0]     tx_q;
   logic           sh_q;
   logic           busy_q;
   logic           done_q;

   logic [3:0]     idx_next;
   logic [7:0]     next_byte;

   // Select the byte that follows the current one. It is loaded into tx_q
   // only when a new SETUP phase starts.
   always_comb begin
      idx_next  = idx_q + 4'd1;
      next_byte = buf_q[{idx_next, 3'b000} +: 8];
   end

   // FSM with registered outputs. Because tx_q is loaded only on entry to
   // SETUP, tx is stable while shakehand is high and on its rising edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         buf_q   <= 128'h0;
         idx_q   <= 4'd0;
         cnt_q   <= 4'd0;
         tx_q    <= 8'h00;
         sh_q    <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (en) begin
                  buf_q   <= data;
                  idx_q   <= 4'd0;
                  cnt_q   <= LOW_RELOAD;
                  tx_q    <= data[7:0];
                  sh_q    <= 1'b0;
                  busy_q  <= 1'b1;
                  state_q <= SETUP;
               end
            end
            SETUP: begin
               if (cnt_q == 4'd0) begin
                  cnt_q   <= HIGH_RELOAD;
                  sh_q    <= 1'b1;
                  state_q <= STROBE;
               end else begin
                  cnt_q <= cnt_q - 4'd1;
               end
            end
            STROBE: begin
               if (cnt_q == 4'd0) begin
                  if (idx_q == 4'd15) begin
                     tx_q    <= 8'h00;
                     sh_q    <= 1'b0;
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                     state_q <= IDLE;
                  end else begin
                     idx_q   <= idx_next;
                     tx_q    <= next_byte;
                     sh_q    <= 1'b0;
                     cnt_q   <= LOW_RELOAD;
                     state_q <= SETUP;
                  end
               end else begin
                  cnt_q <= cnt_q - 4'd1;
               end
            end
            default: begin
               state_q <= IDLE;
               tx_q    <= 8'h00;
               sh_q    <= 1'b0;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign tx        = tx_q;
   assign shakehand = sh_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign state_o   = state_q;

endmodule

// File: tb/tb_aes_tx.sv
// tb_aes_tx: directed bench for aes_tx. Unit A uses the default timing and
// unit B uses single-cycle phases. For unit A, a negedge monitor acts as the
// receive port and scoreboard: expected bytes and blocks are queued when a
// block is driven, and they are compared on each shakehand rising edge.
module tb_aes_tx;

   localparam int L_A = 2;
   localparam int H_A = 2;

   logic         clk;
   logic         rst_n;
   logic [127:0] data_a, data_b;
   logic         en_a, en_b;
   logic [7:0]   tx_a, tx_b;
   logic         sh_a, sh_b;
   logic         busy_a, busy_b;
   logic         done_a, done_b;
   logic [1:0]   state_a, state_b;

   int n_vec = 0;
   int n_err = 0;

   logic [7:0]   exp_q[$];
   logic [127:0] blk_q[$];
   logic [7:0]   exp_b[$];

   // Receive-side monitor state for unit A
   logic         sh_prev, busy_prev;
   logic [7:0]   tx_prev;
   int           low_run, high_run, busy_run, rx_cnt;
   int           rises_a = 0, dones_a = 0, rx_valid_a = 0;
   logic [127:0] rx_word;

   aes_tx dut_a (
      .clk(clk), .rst_n(rst_n), .data(data_a), .en(en_a), .tx(tx_a),
      .shakehand(sh_a), .busy(busy_a), .done(done_a), .state_o(state_a)
   );

   aes_tx #(.STROBE_LOW(1), .STROBE_HIGH(1)) dut_b (
      .clk(clk), .rst_n(rst_n), .data(data_b), .en(en_b), .tx(tx_b),
      .shakehand(sh_b), .busy(busy_b), .done(done_b), .state_o(state_b)
   );

   // Clock generation
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Global time limit
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, observed timeout required finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic push_block(input logic [127:0] d);
      for (int k = 0; k < 16; k++) exp_q.push_back(d[8*k +: 8]);
      blk_q.push_back(d);
   endtask

   // Drive one block into unit A. The task returns on the first busy cycle.
   task automatic send_a(input logic [127:0] d);
      @(negedge clk);
      data_a = d;
      en_a   = 1'b1;
      push_block(d);
      @(negedge clk);
      en_a   = 1'b0;
   endtask

   task automatic wait_done_a(input int budget);
      for (int i = 0; i < budget && !done_a; i++) @(negedge clk);
      check("done_seen", done_a, 1);
   endtask

   // Monitor and receive port for unit A, sampled away from the active edge
   always @(negedge clk) begin
      logic [7:0]   eb;
      logic [127:0] ew;
      if (!rst_n) begin
         sh_prev = 1'b0; busy_prev = 1'b0; tx_prev = 8'h00;
         low_run = 0; high_run = 0; busy_run = 0; rx_cnt = 0;
      end else begin
         check("state_dbg", state_a, busy_a ? (sh_a ? 2'd2 : 2'd1) : 2'd0);
         if (busy_a) busy_run++;
         if (busy_a && !sh_a) low_run++;
         if (sh_a) high_run++;
         if (tx_a !== tx_prev) check("tx_change_sh", sh_a, 0);
         if (!busy_a) begin
            check("idle_tx", tx_a, 8'h00);
            check("idle_sh", sh_a, 0);
         end
         if (sh_a && !sh_prev) begin
            check("low_phase", low_run, L_A);
            low_run = 0;
            rises_a++;
            eb = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
            check("byte", tx_a, eb);
            rx_word = {tx_a, rx_word[127:8]};
            rx_cnt++;
            if (rx_cnt == 16) begin
               rx_cnt = 0;
               rx_valid_a++;
               ew = (blk_q.size() != 0) ? blk_q.pop_front() : 128'hx;
               check("rx_block", rx_word, ew);
            end
         end
         if (!sh_a && sh_prev) begin
            check("high_phase", high_run, H_A);
            high_run = 0;
         end
         if (busy_prev && !busy_a) begin
            check("busy_span", busy_run, 16 * (L_A + H_A));
            check("done_pulse", done_a, 1);
            busy_run = 0;
            dones_a++;
         end else begin
            check("done_low", done_a, 0);
         end
         sh_prev = sh_a; busy_prev = busy_a; tx_prev = tx_a;
      end
   end

   // Directed stimulus sequence
   initial begin
      int r0, d0, v0, bcnt, rb, db;
      logic sp, eb_b;
      logic [7:0] tp, bb;
      logic [127:0] blk_b;

      rst_n = 1'b0; en_a = 1'b0; en_b = 1'b0;
      data_a = 128'h0; data_b = 128'h0;
      rx_word = 128'h0;
      repeat (3) @(negedge clk);
      check("rst_tx", tx_a, 8'h00);
      check("rst_sh", sh_a, 0);
      check("rst_busy", busy_a, 0);
      check("rst_done", done_a, 0);
      check("rst_state", state_a, 2'd0);

      // Release reset with en already high: the first edge accepts the block
      rst_n  = 1'b1;
      data_a = 128'h0F0E0D0C0B0A09080706050403020100;
      en_a   = 1'b1;
      push_block(data_a);
      @(negedge clk);
      en_a = 1'b0;
      check("first_busy", busy_a, 1);
      check("first_tx", tx_a, 8'h00);
      wait_done_a(200);
      @(negedge clk);
      check("t1_rises", rises_a, 16);
      check("t1_dones", dones_a, 1);

      // Loopback: the monitor reassembles the block
      v0 = rx_valid_a;
      send_a(128'h00112233445566778899AABBCCDDEEFF);
      wait_done_a(200);
      @(negedge clk);
      check("loop_valid", rx_valid_a - v0, 1);

      // en during a transfer is ignored
      r0 = rises_a; d0 = dones_a;
      send_a(128'h0);
      repeat (9) @(negedge clk);
      data_a = {128{1'b1}};
      en_a   = 1'b1;
      @(negedge clk);
      en_a   = 1'b0;
      data_a = 128'h0;
      wait_done_a(200);
      repeat (6) @(negedge clk);
      check("ign_rises", rises_a - r0, 16);
      check("ign_dones", dones_a - d0, 1);
      check("ign_idle", busy_a, 0);

      // Reset in busy cycle 30 aborts the transfer
      send_a(128'hDEADBEEF_01234567_89ABCDEF_55AA33CC);
      repeat (29) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("abort_tx", tx_a, 8'h00);
      check("abort_sh", sh_a, 0);
      check("abort_busy", busy_a, 0);
      check("abort_done", done_a, 0);
      exp_q.delete();
      blk_q.delete();
      r0 = rises_a; d0 = dones_a;
      repeat (4) @(negedge clk);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
      check("abort_no_rise", rises_a - r0, 0);
      check("abort_no_done", dones_a - d0, 0);
      check("abort_wait", busy_a, 0);
      send_a(128'hCAFEF00D_11111111_22222222_33333333);
      wait_done_a(200);
      @(negedge clk);
      check("post_abort_rises", rises_a - r0, 16);

      // en held high across two blocks
      r0 = rises_a; d0 = dones_a;
      @(negedge clk);
      data_a = 128'hA0A1A2A3_A4A5A6A7_A8A9AAAB_ACADAEAF;
      en_a   = 1'b1;
      push_block(data_a);
      @(negedge clk);
      data_a = 128'hB0B1B2B3_B4B5B6B7_B8B9BABB_BCBDBEBF;
      push_block(data_a);
      wait_done_a(200);
      @(negedge clk);
      check("b2b_busy", busy_a, 1);
      check("b2b_state", state_a, 2'd1);
      en_a = 1'b0;
      wait_done_a(200);
      @(negedge clk);
      check("b2b_rises", rises_a - r0, 32);
      check("b2b_dones", dones_a - d0, 2);

      // Unit B: single-cycle phases
      blk_b = 128'h8899AABB_CCDDEEFF_00112233_44556677;
      for (int k = 0; k < 16; k++) exp_b.push_back(blk_b[8*k +: 8]);
      check("b_idle_sh", sh_b, 0);
      @(negedge clk);
      data_b = blk_b;
      en_b   = 1'b1;
      @(negedge clk);
      en_b = 1'b0;
      bcnt = 0; rb = 0; db = 0; sp = 1'b0; tp = 8'h00;
      for (int c = 0; c < 40; c++) begin
         if (busy_b) begin
            bcnt++;
            eb_b = ((bcnt % 2) == 0);
            check("b_sh_phase", sh_b, eb_b);
         end
         if (tx_b !== tp) check("b_tx_change_sh", sh_b, 0);
         if (sh_b && !sp) begin
            rb++;
            bb = (exp_b.size() != 0) ? exp_b.pop_front() : 8'hxx;
            check("b_byte", tx_b, bb);
         end
         if (done_b) db++;
         sp = sh_b; tp = tx_b;
         @(negedge clk);
      end
      check("b_busy_span", bcnt, 32);
      check("b_rises", rb, 16);
      check("b_dones", db, 1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
